// File: rtl/seq_pkg.sv
// Shared definitions for the drum step sequencer.
//   NUM_STEPS / NUM_TRACKS : default pattern geometry
//   seq_state_e            : playback state encoding
//   BASS_DRUM .. TOM2      : bit position of each drum track within a step
package seq_pkg;

  localparam int NUM_STEPS  = 16;
  localparam int NUM_TRACKS = 7;

  typedef enum logic [0:0] {
    ST_STOPPED = 1'b0,
    ST_PLAYING = 1'b1
  } seq_state_e;

  localparam int BASS_DRUM = 6;
  localparam int SNARE     = 5;
  localparam int CLAP      = 4;
  localparam int HIHAT     = 3;
  localparam int CYMBAL    = 2;
  localparam int TOM1      = 1;
  localparam int TOM2      = 0;

endpackage

// File: rtl/step_sequencer_if.sv
// Control, edit and playback signals of the step sequencer.
//   master : drives transport, tempo and edit controls; observes playback
//   slave  : the sequencer itself
interface step_sequencer_if #(
  parameter int NUM_STEPS  = seq_pkg::NUM_STEPS,
  parameter int NUM_TRACKS = seq_pkg::NUM_TRACKS
);

  localparam int STEP_W = $clog2(NUM_STEPS);

  logic                  poweron;
  logic                  start;
  logic                  stop;
  logic [23:0]           step_period;
  logic                  edit_toggle;
  logic [STEP_W-1:0]     edit_step;
  logic [2:0]            edit_track;
  logic                  clear;
  logic [NUM_TRACKS-1:0] select;
  logic [NUM_TRACKS-1:0] trigger;
  logic [STEP_W-1:0]     cur_step;
  logic                  step_strobe;
  logic                  running;

  modport master (
    output poweron, start, stop, step_period, edit_toggle, edit_step, edit_track, clear,
    input  select, trigger, cur_step, step_strobe, running
  );

  modport slave (
    input  poweron, start, stop, step_period, edit_toggle, edit_step, edit_track, clear,
    output select, trigger, cur_step, step_strobe, running
  );

endinterface

// File: rtl/seq_pattern_mem.sv
// Pattern register file: NUM_STEPS words of NUM_TRACKS bits.
//   CLK, Reset           : clock, synchronous active-high reset (clears pattern)
//   clear                : zero every bit; wins over a same-cycle toggle
//   toggle, toggle_step,
//   toggle_track         : invert one bit; track indices beyond the word are ignored
//   play_addr/play_data  : read port for the step now playing
//   look_addr/look_data  : read port for the step about to start
module seq_pattern_mem #(
  parameter int NUM_STEPS  = 16,
  parameter int NUM_TRACKS = 7,
  localparam int STEP_W    = $clog2(NUM_STEPS)
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  clear,
  input  logic                  toggle,
  input  logic [STEP_W-1:0]     toggle_step,
  input  logic [2:0]            toggle_track,
  input  logic [STEP_W-1:0]     play_addr,
  output logic [NUM_TRACKS-1:0] play_data,
  input  logic [STEP_W-1:0]     look_addr,
  output logic [NUM_TRACKS-1:0] look_data
);

  logic [NUM_TRACKS-1:0] mem_q [NUM_STEPS];
  logic                  track_ok;

  assign track_ok = int'(toggle_track) < NUM_TRACKS;

  always_ff @(posedge CLK) begin
    if (Reset || clear) begin
      for (int s = 0; s < NUM_STEPS; s++) mem_q[s] <= '0;
    end else if (toggle && track_ok) begin
      mem_q[toggle_step][toggle_track] <= ~mem_q[toggle_step][toggle_track];
    end
  end

  assign play_data = mem_q[play_addr];
  assign look_data = mem_q[look_addr];

endmodule

// File: rtl/step_sequencer.sv
// Drum step sequencer: plays a NUM_STEPS x NUM_TRACKS pattern, one step every
// step_period clocks (minimum 2), pulsing trigger/step_strobe at each step start.
//   CLK   : system clock
//   Reset : synchronous active-high reset, overrides everything
//   bus   : transport, tempo, edit controls in; select/trigger/cur_step/
//           step_strobe/running out
//
//   state   | meaning
//   STOPPED | idle, all playback outputs zero
//   PLAYING | stepping through the pattern
module step_sequencer #(
  parameter int NUM_STEPS  = seq_pkg::NUM_STEPS,
  parameter int NUM_TRACKS = seq_pkg::NUM_TRACKS
) (
  input logic             CLK,
  input logic             Reset,
  step_sequencer_if.slave bus
);

  import seq_pkg::*;

  localparam int STEP_W = $clog2(NUM_STEPS);

  localparam logic [0:0] STOPPED = 1'(ST_STOPPED);
  localparam logic [0:0] PLAYING = 1'(ST_PLAYING);

  logic [0:0]            state_q;
  logic [23:0]           tick_q;
  logic [23:0]           period_q;
  logic [STEP_W-1:0]     step_q;
  logic [STEP_W-1:0]     step_nxt;
  logic [STEP_W-1:0]     look_addr;
  logic [NUM_TRACKS-1:0] select_q;
  logic [NUM_TRACKS-1:0] trigger_q;
  logic                  strobe_q;
  logic [NUM_TRACKS-1:0] play_data;
  logic [NUM_TRACKS-1:0] look_data;
  logic [23:0]           period_ld;
  logic                  boundary;
  logic                  halt;

  assign step_nxt  = step_q + 1'b1;
  // A start always plays step 0, so the lookahead port is redirected there.
  assign look_addr = bus.start ? '0 : step_nxt;
  assign period_ld = (bus.step_period < 24'd2) ? 24'd2 : bus.step_period;
  assign boundary  = (tick_q == period_q - 24'd1);
  assign halt      = bus.stop || !bus.poweron;

  seq_pattern_mem #(
    .NUM_STEPS  (NUM_STEPS),
    .NUM_TRACKS (NUM_TRACKS)
  ) u_mem (
    .CLK          (CLK),
    .Reset        (Reset),
    .clear        (bus.clear),
    .toggle       (bus.edit_toggle),
    .toggle_step  (bus.edit_step),
    .toggle_track (bus.edit_track),
    .play_addr    (step_q),
    .play_data    (play_data),
    .look_addr    (look_addr),
    .look_data    (look_data)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= STOPPED;
      tick_q    <= '0;
      period_q  <= '0;
      step_q    <= '0;
      select_q  <= '0;
      trigger_q <= '0;
      strobe_q  <= 1'b0;
    end else if (halt) begin
      state_q   <= STOPPED;
      tick_q    <= '0;
      step_q    <= '0;
      select_q  <= '0;
      trigger_q <= '0;
      strobe_q  <= 1'b0;
    end else if (bus.start) begin
      state_q   <= PLAYING;
      tick_q    <= '0;
      period_q  <= period_ld;
      step_q    <= '0;
      select_q  <= look_data;
      trigger_q <= look_data;
      strobe_q  <= 1'b1;
    end else if (state_q == PLAYING) begin
      if (boundary) begin
        tick_q    <= '0;
        period_q  <= period_ld;
        step_q    <= step_nxt;
        select_q  <= look_data;
        trigger_q <= look_data;
        strobe_q  <= 1'b1;
      end else begin
        tick_q    <= tick_q + 24'd1;
        // Tracks live edits of the current step without retriggering.
        select_q  <= play_data;
        trigger_q <= '0;
        strobe_q  <= 1'b0;
      end
    end else begin
      trigger_q <= '0;
      strobe_q  <= 1'b0;
    end
  end

  assign bus.select      = select_q;
  assign bus.trigger     = trigger_q;
  assign bus.cur_step    = step_q;
  assign bus.step_strobe = strobe_q;
  assign bus.running     = (state_q == PLAYING);

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 SHALL have parameter NUM_STEPS, 16, pattern length in steps (power of two).
REQ-002 SHALL have parameter NUM_TRACKS, 7, drum tracks per step; bit 6 is bass drum, then snare, clap, hihat, cymbal, tom1, down to bit 0 tom2.
REQ-003 SHALL have port CLK  in  1  system clock; one clock domain, all logic on posedge CLK.
REQ-004 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port poweron  in  1  level; low forces the stopped behaviour.
REQ-006 SHALL have port start  in  1  one-cycle pulse; begin playback at step 0.
REQ-007 SHALL have port stop  in  1  one-cycle pulse; halt playback.
REQ-008 SHALL have port step_period  in  24  clock cycles per step.
REQ-009 SHALL have port edit_toggle  in  1  pulse; invert pattern bit [edit_step][edit_track].
REQ-010 SHALL have port edit_step  in  log2(NUM_STEPS)  step index for edits.
REQ-011 SHALL have port edit_track  in  3  track index for edits.
REQ-012 SHALL have port clear  in  1  pulse; zero the entire pattern.
REQ-013 SHALL have port select  out  NUM_TRACKS  track mask of the current step, feeding the sample mixer.
REQ-014 SHALL have port trigger  out  NUM_TRACKS  one-cycle pulse per active track at each step start.
REQ-015 SHALL have port cur_step  out  log2(NUM_STEPS)  index of the step now playing.
REQ-016 SHALL have port step_strobe  out  1  one-cycle pulse at each step start.
REQ-017 SHALL have port running  out  1  high while in PLAYING.

Function
REQ-018 SHALL implement two states, STOPPED and PLAYING; running = (state == PLAYING).
REQ-019 In STOPPED:
- start high and poweron high -> PLAYING on the next cycle.
- On that cycle: cur_step=0, step_strobe=1, trigger=pattern[0], select=pattern[0], tick counter=0.
REQ-020 In PLAYING:
- Tick counter increments each cycle.
- At count == period_q-1: counter returns to 0 and cur_step advances, wrapping NUM_STEPS-1 -> 0.
- On the following cycle: step_strobe=1 and trigger=pattern[new step].
- Each step therefore lasts exactly period_q cycles.
REQ-021 period_q SHALL be loaded with max(step_period, 2) on start and at every step boundary; mid-step changes take effect from the next step.
REQ-022 In PLAYING, select SHALL continuously reflect pattern[cur_step] with one-cycle latency, so a live edit of the current step changes select without re-issuing trigger.
REQ-023 stop, or poweron low, SHALL give on the next cycle:
- state STOPPED
- select=0, trigger=0, step_strobe=0
- cur_step=0, tick counter=0
REQ-024 start while PLAYING SHALL restart at step 0 exactly as in REQ-019.
REQ-025 Simultaneous start and stop: stop wins.
REQ-026 clear SHALL zero all pattern bits.
REQ-027 clear and edit_toggle in the same cycle: clear wins.
REQ-028 edit_toggle with edit_track >= NUM_TRACKS SHALL be ignored.
REQ-029 Edits and clear SHALL be accepted in either state and while poweron is low; the pattern is retained across stop and poweron low.
REQ-030 In STOPPED, trigger and step_strobe SHALL be zero.

Reset
REQ-031 Reset high SHALL, on the next cycle:
- set state to STOPPED
- clear the pattern
- zero tick counter, period_q, cur_step, select, trigger, step_strobe and running
REQ-032 Reset SHALL override every other input, including mid-step.

Structure
REQ-033 A shared package seq_pkg SHALL hold:
- NUM_STEPS and NUM_TRACKS
- the state enum
- the track index constants, BASS_DRUM=6 through TOM2=0
REQ-034 Pattern storage SHALL be a sub-module, seq_pattern_mem:
- NUM_STEPS x NUM_TRACKS register file
- one toggle write port and a clear
- two read ports: playback and trigger lookahead

Verification
REQ-035 Program pattern[0]=7'b1000001 and pattern[1]=7'b0100000, step_period=4, then pulse start. Required: strobe every 4 cycles; select 1000001 for 4 cycles, then 0100000; trigger pulses 1000001 at t+1 and 0100000 at t+5.
REQ-036 step_period=1 with NUM_STEPS=16. Required: steps last 2 cycles; cur_step wraps 15->0 after 32 cycles.
REQ-037 Pulse stop mid-step 3. Required: next cycle select=0, cur_step=0, running=0. A later start replays from step 0.
REQ-038 Set step_period=10 during a 4-cycle step, toggle the current step's bit 2 while playing, and drive start and stop together. Required:
- new period applies from the next step
- select bit 2 changes on the next cycle with no trigger
- stop wins
REQ-039 Pulse clear and edit_toggle together, toggle with edit_track=7, then assert Reset mid-play. Required: pattern all-zero; the track-7 edit is ignored; all outputs are zero on the next cycle.
